// File: rtl/ppu_vram_arb.sv
// PPU VRAM port arbiter: background, sprite and CPU requesters share
// one synchronous RAM port through an address/wait/data sequence.
module ppu_vram_arb #(
    parameter int RD_LAT         = 1,
    parameter int CPU_STARVE_MAX = 15
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        render_en_in,
    input  logic        bg_req_in,
    input  logic [13:0] bg_a_in,
    output logic        bg_gnt_out,
    input  logic        spr_req_in,
    input  logic [13:0] spr_a_in,
    output logic        spr_gnt_out,
    input  logic        cpu_req_in,
    input  logic        cpu_wr_in,
    input  logic [13:0] cpu_a_in,
    input  logic [7:0]  cpu_d_in,
    output logic        cpu_done_out,
    output logic        rd_vld_out,
    output logic [1:0]  rd_src_out,
    output logic [7:0]  rd_d_out,
    output logic [13:0] vram_a_out,
    output logic [7:0]  vram_d_out,
    output logic        vram_wr_out,
    input  logic [7:0]  vram_d_in
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        WAIT,
        DATA
    } state_t;

    localparam logic [1:0] SRC_BG     = 2'd0;
    localparam logic [1:0] SRC_SPR    = 2'd1;
    localparam logic [1:0] SRC_CPU    = 2'd2;
    localparam logic [7:0] STARVE_MAX = 8'(CPU_STARVE_MAX);
    localparam logic [1:0] WAIT_LD    = 2'(RD_LAT - 1);

    state_t      state_q;
    logic [1:0]  src_q;
    logic        wr_q;
    logic [1:0]  wait_q;
    logic [7:0]  starve_q;

    logic        cpu_act;
    logic        starved;
    logic        pick_bg;
    logic        pick_spr;
    logic        pick_cpu;
    logic        to_data;
    logic [13:0] win_a;
    logic [1:0]  win_src;

    // A CPU write finishes while the CPU still holds its request, so the
    // request is ignored during its own done pulse to avoid a re-grant.
    assign cpu_act = cpu_req_in & ~cpu_done_out;
    assign starved = (starve_q == STARVE_MAX);

    // The read return registers load on the edge that enters DATA, so the
    // data is visible during the DATA cycle itself.
    assign to_data = ((state_q == ADDR) && !wr_q && (RD_LAT == 1)) ||
                     ((state_q == WAIT) && (wait_q == 2'd1));

    // Priority selection among the eligible requesters
    always_comb begin
        pick_bg  = 1'b0;
        pick_spr = 1'b0;
        pick_cpu = 1'b0;
        if (render_en_in) begin
            if (cpu_act && starved) begin
                pick_cpu = 1'b1;
            end else if (bg_req_in) begin
                pick_bg = 1'b1;
            end else if (spr_req_in) begin
                pick_spr = 1'b1;
            end else if (cpu_act) begin
                pick_cpu = 1'b1;
            end
        end else begin
            pick_cpu = cpu_act;
        end
    end

    // Address and source of the winning requester
    always_comb begin
        win_a   = cpu_a_in;
        win_src = SRC_CPU;
        unique case (1'b1)
            pick_bg: begin
                win_a   = bg_a_in;
                win_src = SRC_BG;
            end
            pick_spr: begin
                win_a   = spr_a_in;
                win_src = SRC_SPR;
            end
            default: ;
        endcase
    end

    // Access sequencer with registered outputs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            src_q        <= SRC_BG;
            wr_q         <= 1'b0;
            wait_q       <= 2'd0;
            bg_gnt_out   <= 1'b0;
            spr_gnt_out  <= 1'b0;
            cpu_done_out <= 1'b0;
            rd_vld_out   <= 1'b0;
            rd_src_out   <= 2'd0;
            rd_d_out     <= 8'd0;
            vram_a_out   <= 14'd0;
            vram_d_out   <= 8'd0;
            vram_wr_out  <= 1'b0;
        end else begin
            bg_gnt_out   <= 1'b0;
            spr_gnt_out  <= 1'b0;
            cpu_done_out <= 1'b0;
            rd_vld_out   <= 1'b0;
            vram_wr_out  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_bg || pick_spr || pick_cpu) begin
                        state_q     <= ADDR;
                        vram_a_out  <= win_a;
                        src_q       <= win_src;
                        wr_q        <= pick_cpu & cpu_wr_in;
                        vram_wr_out <= pick_cpu & cpu_wr_in;
                        vram_d_out  <= (pick_cpu & cpu_wr_in) ? cpu_d_in : 8'd0;
                        bg_gnt_out  <= pick_bg;
                        spr_gnt_out <= pick_spr;
                    end
                end
                ADDR: begin
                    vram_d_out <= 8'd0;
                    if (wr_q) begin
                        cpu_done_out <= 1'b1;
                        state_q      <= IDLE;
                    end else if (RD_LAT == 1) begin
                        state_q <= DATA;
                    end else begin
                        wait_q  <= WAIT_LD;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    wait_q <= wait_q - 2'd1;
                    if (wait_q == 2'd1) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            if (to_data) begin
                rd_d_out     <= vram_d_in;
                rd_src_out   <= src_q;
                rd_vld_out   <= 1'b1;
                cpu_done_out <= (src_q == SRC_CPU);
            end
        end
    end

    // CPU starvation counter, only advanced by lost IDLE slots while rendering
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            starve_q <= 8'd0;
        end else if (!cpu_req_in) begin
            starve_q <= 8'd0;
        end else if (state_q == IDLE) begin
            if (pick_cpu) begin
                starve_q <= 8'd0;
            end else if (render_en_in && cpu_act && !starved) begin
                starve_q <= starve_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ppu_vram_arb.sv
// Directed bench for ppu_vram_arb: table of single accesses plus
// starvation, render gating, RD_LAT=3 throughput and reset-abort sequences.
module tb_ppu_vram_arb;

    logic        clk_in;
    logic        rst_in;
    logic        render;
    logic        bg_req;
    logic [13:0] bg_a;
    logic        spr_req;
    logic [13:0] spr_a;
    logic        cpu_req;
    logic        cpu_wr;
    logic [13:0] cpu_a;
    logic [7:0]  cpu_d;
    logic [7:0]  din1;
    logic [7:0]  din3;

    logic        bg_gnt1, spr_gnt1, done1, vld1, wr1;
    logic [1:0]  src1;
    logic [7:0]  rd1, d1o;
    logic [13:0] a1;

    logic        bg_gnt3, spr_gnt3, done3, vld3, wr3;
    logic [1:0]  src3;
    logic [7:0]  rd3, d3o;
    logic [13:0] a3;

    logic [7:0]  mem [16384];
    logic [7:0]  p1, p2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic        rnd;
        logic [1:0]  who;
        logic        wr;
        logic [13:0] a;
        logic [7:0]  d;
        logic [7:0]  exp;
    } vec_t;

    vec_t vt [8];

    ppu_vram_arb #(.RD_LAT(1), .CPU_STARVE_MAX(15)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .render_en_in(render),
        .bg_req_in(bg_req), .bg_a_in(bg_a), .bg_gnt_out(bg_gnt1),
        .spr_req_in(spr_req), .spr_a_in(spr_a), .spr_gnt_out(spr_gnt1),
        .cpu_req_in(cpu_req), .cpu_wr_in(cpu_wr), .cpu_a_in(cpu_a),
        .cpu_d_in(cpu_d), .cpu_done_out(done1), .rd_vld_out(vld1),
        .rd_src_out(src1), .rd_d_out(rd1), .vram_a_out(a1),
        .vram_d_out(d1o), .vram_wr_out(wr1), .vram_d_in(din1)
    );

    ppu_vram_arb #(.RD_LAT(3), .CPU_STARVE_MAX(15)) dut3 (
        .clk_in(clk_in), .rst_in(rst_in), .render_en_in(render),
        .bg_req_in(bg_req), .bg_a_in(bg_a), .bg_gnt_out(bg_gnt3),
        .spr_req_in(spr_req), .spr_a_in(spr_a), .spr_gnt_out(spr_gnt3),
        .cpu_req_in(cpu_req), .cpu_wr_in(cpu_wr), .cpu_a_in(cpu_a),
        .cpu_d_in(cpu_d), .cpu_done_out(done3), .rd_vld_out(vld3),
        .rd_src_out(src3), .rd_d_out(rd3), .vram_a_out(a3),
        .vram_d_out(d3o), .vram_wr_out(wr3), .vram_d_in(din3)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: RAM write at the edge, then RAM read models after it.
    task automatic tick();
        if (wr1 === 1'b1) mem[a1] = d1o;
        @(posedge clk_in);
        #1;
        cyc++;
        din1 = mem[a1];
        din3 = p2;
        p2   = p1;
        p1   = mem[a3];
    endtask

    initial begin
        int nbg;
        int nspr;
        int nv;
        int ng;
        int last;
        int bad;
        logic found;
        logic [13:0] sa [3];
        logic [7:0]  se [3];

        for (int i = 0; i < 16384; i++) mem[i] = 8'(i * 7 + 3);
        mem[14'h2005] = 8'hA7;
        mem[14'h0123] = 8'h5A;
        mem[14'h1FF0] = 8'hC3;
        mem[14'h2400] = 8'h00;
        mem[14'h3F00] = 8'h00;
        p1 = 8'd0; p2 = 8'd0; din1 = 8'd0; din3 = 8'd0;

        vt[0] = '{1'b0, 2'd2, 1'b0, 14'h2005, 8'h00, 8'hA7};
        vt[1] = '{1'b0, 2'd2, 1'b1, 14'h3F00, 8'h1C, 8'h00};
        vt[2] = '{1'b0, 2'd2, 1'b0, 14'h3F00, 8'h00, 8'h1C};
        vt[3] = '{1'b1, 2'd0, 1'b0, 14'h0123, 8'h00, 8'h5A};
        vt[4] = '{1'b1, 2'd1, 1'b0, 14'h1FF0, 8'h00, 8'hC3};
        vt[5] = '{1'b1, 2'd2, 1'b0, 14'h2005, 8'h00, 8'hA7};
        vt[6] = '{1'b1, 2'd2, 1'b1, 14'h2400, 8'h99, 8'h00};
        vt[7] = '{1'b0, 2'd2, 1'b0, 14'h2400, 8'h00, 8'h99};

        rst_in = 1'b0; render = 1'b0;
        bg_req = 1'b0; bg_a = 14'd0;
        spr_req = 1'b0; spr_a = 14'd0;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_a = 14'd0; cpu_d = 8'd0;
        tick();
        tick();
        chk("rst_addr", 32'(a1), 32'h0);
        chk("rst_vld", 32'(vld1), 32'h0);
        chk("rst_done", 32'(done1), 32'h0);
        chk("rst_rd", 32'(rd1), 32'h0);
        chk("rst_wr", 32'({wr1, d1o}), 32'h0);
        chk("rst_gnt", 32'({bg_gnt1, spr_gnt1, src1}), 32'h0);
        chk("rst_starve", 32'(dut.starve_q), 32'h0);
        rst_in = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            render  = vt[i].rnd;
            bg_req  = (vt[i].who == 2'd0);
            spr_req = (vt[i].who == 2'd1);
            cpu_req = (vt[i].who == 2'd2);
            bg_a    = vt[i].a;
            spr_a   = vt[i].a;
            cpu_a   = vt[i].a;
            cpu_wr  = vt[i].wr;
            cpu_d   = vt[i].d;
            tick();
            chk($sformatf("v%0d_addr", i), 32'(a1), 32'(vt[i].a));
            chk($sformatf("v%0d_bg_gnt", i), 32'(bg_gnt1),
                32'(vt[i].who == 2'd0));
            chk($sformatf("v%0d_spr_gnt", i), 32'(spr_gnt1),
                32'(vt[i].who == 2'd1));
            chk($sformatf("v%0d_wr", i), 32'(wr1), 32'(vt[i].wr));
            if (vt[i].wr) chk($sformatf("v%0d_wdata", i), 32'(d1o),
                              32'(vt[i].d));
            chk($sformatf("v%0d_early", i), 32'({vld1, done1}), 32'h0);
            tick();
            bg_req = 1'b0; spr_req = 1'b0; cpu_req = 1'b0;
            chk($sformatf("v%0d_gnt_off", i), 32'({bg_gnt1, spr_gnt1}), 32'h0);
            if (vt[i].wr) begin
                chk($sformatf("v%0d_wdone", i), 32'(done1), 32'h1);
                chk($sformatf("v%0d_wnovld", i), 32'(vld1), 32'h0);
                chk($sformatf("v%0d_wroff", i), 32'(wr1), 32'h0);
            end else begin
                chk($sformatf("v%0d_vld", i), 32'(vld1), 32'h1);
                chk($sformatf("v%0d_src", i), 32'(src1), 32'(vt[i].who));
                chk($sformatf("v%0d_data", i), 32'(rd1), 32'(vt[i].exp));
                chk($sformatf("v%0d_done", i), 32'(done1),
                    32'(vt[i].who == 2'd2));
            end
            tick();
            chk($sformatf("v%0d_quiet", i), 32'({vld1, done1, wr1}), 32'h0);
        end

        render = 1'b1;
        bg_req = 1'b1; bg_a = 14'h0123;
        spr_req = 1'b1; spr_a = 14'h1FF0;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_a = 14'h2005;
        nbg = 0; nspr = 0; found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            tick();
            if (bg_gnt1) nbg++;
            if (spr_gnt1) nspr++;
            if (done1) found = 1'b1;
        end
        chk("starve_cpu_served", 32'(found), 32'h1);
        chk("starve_bg_wins", 32'(nbg), 32'd15);
        chk("starve_spr_wins", 32'(nspr), 32'd0);
        chk("starve_src", 32'(src1), 32'd2);
        chk("starve_data", 32'(rd1), 32'hA7);
        chk("starve_cleared", 32'(dut.starve_q), 32'h0);
        bg_req = 1'b0; spr_req = 1'b0; cpu_req = 1'b0;
        tick();
        tick();
        tick();

        render = 1'b0;
        bg_req = 1'b1; bg_a = 14'h0123;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bg_gnt1 !== 1'b0) bad++;
        end
        chk("norender_bg_blocked", 32'(bad), 32'd0);
        render = 1'b1;
        tick();
        chk("render_bg_gnt", 32'(bg_gnt1), 32'h1);
        bg_req = 1'b0;
        tick();
        chk("render_bg_vld", 32'(vld1), 32'h1);
        chk("render_bg_src", 32'(src1), 32'd0);
        chk("render_bg_data", 32'(rd1), 32'h5A);
        tick();

        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        tick();
        sa[0] = 14'h0123; sa[1] = 14'h1FF0; sa[2] = 14'h2005;
        se[0] = 8'h5A;    se[1] = 8'hC3;    se[2] = 8'hA7;
        render = 1'b1;
        spr_req = 1'b1; spr_a = sa[0];
        nv = 0; ng = 0; last = 0;
        for (int k = 0; k < 60 && nv < 4; k++) begin
            tick();
            if (spr_gnt3) begin
                ng++;
                spr_a = sa[ng % 3];
            end
            if (vld3) begin
                chk($sformatf("lat3_data%0d", nv), 32'(rd3), 32'(se[nv % 3]));
                chk($sformatf("lat3_src%0d", nv), 32'(src3), 32'd1);
                if (nv > 0) chk($sformatf("lat3_gap%0d", nv),
                                32'(cyc - last), 32'd5);
                last = cyc;
                nv++;
            end
        end
        chk("lat3_count", 32'(nv), 32'd4);
        spr_req = 1'b0;
        for (int k = 0; k < 6; k++) tick();

        render = 1'b0;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_a = 14'h2005;
        tick();
        tick();
        #2;
        rst_in = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk("arst_addr", 32'(a3), 32'h0);
        chk("arst_vld", 32'({vld3, vld1}), 32'h0);
        chk("arst_done", 32'({done3, done1}), 32'h0);
        chk("arst_rd", 32'({rd3, src3}), 32'h0);
        chk("arst_wr", 32'({wr3, d3o, bg_gnt3, spr_gnt3}), 32'h0);
        #2;
        rst_in = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done3 || vld3 || wr3 || done1 || vld1) bad++;
        end
        chk("arst_no_late_done", 32'(bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
